// File: rtl/seg_disp_arbiter_if.sv
// Bundle of requester inputs and display-driver outputs shared by the
// seg_disp_arbiter and whatever feeds and consumes it.
interface seg_disp_arbiter_if;
  logic [2:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  ack;
  logic [1:0]  owner;
  logic [31:0] disp_data;
  logic        En;

  modport master (
    output req, data0, data1, data2,
    input  ack, owner, disp_data, En
  );

  modport slave (
    input  req, data0, data1, data2,
    output ack, owner, disp_data, En
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of a single 8-digit 7-segment display: each owner keeps
// the display for a minimum dwell, with an optional blanked gap between owners.
module seg_disp_arbiter #(
  parameter int DWELL_CYC = 50_000_000,
  parameter int BLANK_CYC = 250_000,
  parameter int CNT_W     = 26
) (
  input  logic               Clk,
  input  logic               Rst_n,
  seg_disp_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       owner_q;
  logic [2:0]       ack_q;
  logic [31:0]      disp_q;
  logic             en_q;

  logic [1:0]  nxt1, nxt2, win_idx;
  logic        any_req, other_req, own_req;
  logic [31:0] win_data, own_data;

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  function automatic logic [31:0] data_at(input logic [1:0] idx, input logic [31:0] d0,
                                          input logic [31:0] d1, input logic [31:0] d2);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  // Search order from the current owner is o+1, o+2, then o itself.
  always_comb begin
    nxt1      = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
    nxt2      = (owner_q == 2'd0) ? 2'd2 : owner_q - 2'd1;
    any_req   = |bus.req;
    own_req   = bit_at(bus.req, owner_q);
    other_req = bit_at(bus.req, nxt1) | bit_at(bus.req, nxt2);
    if (bit_at(bus.req, nxt1))      win_idx = nxt1;
    else if (bit_at(bus.req, nxt2)) win_idx = nxt2;
    else                            win_idx = owner_q;
    win_data  = data_at(win_idx, bus.data0, bus.data1, bus.data2);
    own_data  = data_at(owner_q, bus.data0, bus.data1, bus.data2);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= 2'd2;
      ack_q   <= 3'b000;
      disp_q  <= 32'h0;
      en_q    <= 1'b0;
    end else begin
      ack_q <= 3'b000;
      case (state_q)
        ST_IDLE: begin
          en_q <= 1'b0;
          if (any_req) begin
            owner_q <= win_idx;
            ack_q   <= 3'b001 << win_idx;
            disp_q  <= win_data;
            en_q    <= 1'b1;
            cnt_q   <= DWELL_LD;
            state_q <= ST_SHOW;
          end
        end

        ST_SHOW: begin
          if (own_req) disp_q <= own_data;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (other_req) begin
            if (BLANK_CYC == 0) begin
              owner_q <= win_idx;
              ack_q   <= 3'b001 << win_idx;
              disp_q  <= win_data;
              en_q    <= 1'b1;
              cnt_q   <= DWELL_LD;
            end else begin
              en_q    <= 1'b0;
              cnt_q   <= BLANK_LD;
              state_q <= ST_GAP;
            end
          end else if (own_req) begin
            cnt_q <= DWELL_LD;
          end else begin
            en_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_GAP: begin
          en_q <= 1'b0;
          // The winner is recomputed here so requests that changed during the gap count.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (any_req) begin
            owner_q <= win_idx;
            ack_q   <= 3'b001 << win_idx;
            disp_q  <= win_data;
            en_q    <= 1'b1;
            cnt_q   <= DWELL_LD;
            state_q <= ST_SHOW;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          en_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.owner     = owner_q;
  assign bus.disp_data = disp_q;
  assign bus.En        = en_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter: one instance with a blanking gap and
// one with no gap, sharing clock and reset.
module tb_seg_disp_arbiter;

  logic Clk;
  logic Rst_n;
  int   n_assert;
  int   n_fail;

  seg_disp_arbiter_if bus_a ();
  seg_disp_arbiter_if bus_b ();

  seg_disp_arbiter #(.DWELL_CYC(8), .BLANK_CYC(2), .CNT_W(4)) dut_a (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_a)
  );

  seg_disp_arbiter #(.DWELL_CYC(8), .BLANK_CYC(0), .CNT_W(4)) dut_b (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic clear_inputs();
    bus_a.req = 3'b000; bus_a.data0 = 32'h0; bus_a.data1 = 32'h0; bus_a.data2 = 32'h0;
    bus_b.req = 3'b000; bus_b.data0 = 32'h0; bus_b.data1 = 32'h0; bus_b.data2 = 32'h0;
  endtask

  task automatic do_reset();
    tick();
    Rst_n = 1'b0;
    clear_inputs();
    tick();
    Rst_n = 1'b1;
  endtask

  logic [31:0] dv [3];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Rst_n    = 1'b0;
    clear_inputs();

    // Reset state
    tick(); tick();
    chk("rst_en",    32'(bus_a.En),  32'h0);
    chk("rst_disp",  bus_a.disp_data, 32'h0);
    chk("rst_ack",   32'(bus_a.ack), 32'h0);
    chk("rst_owner", 32'(bus_a.owner), 32'h2);
    Rst_n = 1'b1;

    // Single requester, grant latency and live data
    tick();
    bus_a.req = 3'b001; bus_a.data0 = 32'h12345678;
    tick();
    chk("single_ack",   32'(bus_a.ack), 32'h1);
    chk("single_en",    32'(bus_a.En),  32'h1);
    chk("single_disp",  bus_a.disp_data, 32'h12345678);
    chk("single_owner", 32'(bus_a.owner), 32'h0);
    tick();
    chk("single_ack_clr", 32'(bus_a.ack), 32'h0);
    bus_a.data0 = 32'hCAFE0000;
    tick();
    chk("single_live", bus_a.disp_data, 32'hCAFE0000);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("hold_ack_%0d", i), 32'(bus_a.ack), 32'h0);
      chk($sformatf("hold_en_%0d", i),  32'(bus_a.En),  32'h1);
    end

    // Asynchronous reset in the middle of a dwell
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_en",    32'(bus_a.En),  32'h0);
    chk("arst_disp",  bus_a.disp_data, 32'h0);
    chk("arst_ack",   32'(bus_a.ack), 32'h0);
    chk("arst_owner", 32'(bus_a.owner), 32'h2);
    clear_inputs();
    tick();
    Rst_n = 1'b1;

    // Round robin with all three requesting: 0,1,2,0
    dv[0] = 32'hA0A0A0A0; dv[1] = 32'hB1B1B1B1; dv[2] = 32'hC2C2C2C2;
    tick();
    bus_a.data0 = dv[0]; bus_a.data1 = dv[1]; bus_a.data2 = dv[2];
    bus_a.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      int w;
      w = g % 3;
      tick();
      chk($sformatf("rr%0d_ack", g),   32'(bus_a.ack), 32'(3'b001 << w));
      chk($sformatf("rr%0d_owner", g), 32'(bus_a.owner), 32'(w));
      chk($sformatf("rr%0d_disp", g),  bus_a.disp_data, dv[w]);
      chk($sformatf("rr%0d_en", g),    32'(bus_a.En), 32'h1);
      if (g == 3) break;
      for (int c = 1; c < 8; c++) begin
        tick();
        chk($sformatf("rr%0d_dwell_en_%0d", g, c), 32'(bus_a.En), 32'h1);
      end
      for (int c = 0; c < 2; c++) begin
        tick();
        chk($sformatf("rr%0d_gap_en_%0d", g, c), 32'(bus_a.En), 32'h0);
        chk($sformatf("rr%0d_gap_ack_%0d", g, c), 32'(bus_a.ack), 32'h0);
      end
    end

    // Early drop: owner 1 releases after two cycles, dwell still honoured
    do_reset();
    bus_a.data1 = 32'h11110000; bus_a.req = 3'b010;
    tick();
    chk("drop_ack", 32'(bus_a.ack), 32'h2);
    chk("drop_disp0", bus_a.disp_data, 32'h11110000);
    bus_a.data1 = 32'h22220000;
    tick();
    bus_a.req = 3'b000; bus_a.data1 = 32'h33330000;
    tick();
    chk("drop_disp2", bus_a.disp_data, 32'h22220000);
    for (int c = 3; c < 8; c++) begin
      tick();
      chk($sformatf("drop_en_%0d", c),   32'(bus_a.En), 32'h1);
      chk($sformatf("drop_frz_%0d", c), bus_a.disp_data, 32'h22220000);
    end
    tick();
    chk("drop_idle_en", 32'(bus_a.En), 32'h0);
    chk("drop_idle_disp", bus_a.disp_data, 32'h22220000);
    tick();
    chk("drop_idle_ack", 32'(bus_a.ack), 32'h0);

    // No blanking gap: 0 -> 1 handover with En held high
    do_reset();
    bus_b.data0 = 32'h00000B00; bus_b.data1 = 32'h00000B01; bus_b.req = 3'b011;
    tick();
    chk("nogap_ack0", 32'(bus_b.ack), 32'h1);
    chk("nogap_own0", 32'(bus_b.owner), 32'h0);
    for (int c = 1; c < 8; c++) begin
      tick();
      chk($sformatf("nogap_en_%0d", c), 32'(bus_b.En), 32'h1);
      chk($sformatf("nogap_noack_%0d", c), 32'(bus_b.ack), 32'h0);
    end
    tick();
    chk("nogap_ack1", 32'(bus_b.ack), 32'h2);
    chk("nogap_own1", 32'(bus_b.owner), 32'h1);
    chk("nogap_en8",  32'(bus_b.En), 32'h1);
    chk("nogap_disp", bus_b.disp_data, 32'h00000B01);

    // Re-arbitration at gap end picks up a request that rose during the gap
    do_reset();
    bus_a.data0 = 32'hD0D0D0D0; bus_a.data1 = 32'hD1D1D1D1; bus_a.data2 = 32'hD2D2D2D2;
    bus_a.req = 3'b001;
    tick();
    chk("rearb_ack0", 32'(bus_a.ack), 32'h1);
    bus_a.req = 3'b010;
    for (int c = 1; c < 8; c++) tick();
    chk("rearb_en7", 32'(bus_a.En), 32'h1);
    tick();
    chk("rearb_gap_en", 32'(bus_a.En), 32'h0);
    bus_a.req = 3'b100;
    tick();
    chk("rearb_gap_en2", 32'(bus_a.En), 32'h0);
    tick();
    chk("rearb_ack2",  32'(bus_a.ack), 32'h4);
    chk("rearb_owner", 32'(bus_a.owner), 32'h2);
    chk("rearb_disp",  bus_a.disp_data, 32'hD2D2D2D2);
    chk("rearb_en",    32'(bus_a.En), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
